// File: rtl/mmio_uart_responder_pkg.sv
// Shared constants and state encodings for the MMIO UART responder.
package mmio_pkg;

  localparam logic [3:0] IO_REGION  = 4'h8;

  localparam logic [3:0] OFF_TXCTRL = 4'd0;
  localparam logic [3:0] OFF_RXCTRL = 4'd1;
  localparam logic [3:0] OFF_TXDATA = 4'd2;
  localparam logic [3:0] OFF_RXDATA = 4'd3;
  localparam logic [3:0] OFF_CYCLES = 4'd4;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/mmio_uart_responder_if.sv
// CPU-side IO bus: X-stage request signals and M-stage load data.
interface mmio_uart_responder_if;
  logic [31:0] addr;
  logic [3:0]  store_mask;
  logic [31:0] wd;
  logic        rd_en;
  logic [31:0] rd_data;

  modport master (output addr, output store_mask, output wd, output rd_en, input rd_data);
  modport slave  (input addr, input store_mask, input wd, input rd_en, output rd_data);
endinterface

// File: rtl/mmio_uart_responder_uart_rx_fsm.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, 8N1 deserializer.
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronized low
// RX_START | timing to mid start bit; high there means false start
// RX_DATA  | sampling 8 data bits at mid-bit, LSB first
// RX_STOP  | sampling stop bit; low is a framing error and drops the byte
module uart_rx_fsm
  import mmio_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in_i,
  output logic [7:0] byte_o,
  output logic       done_o
);

  localparam int TW = $clog2(SYMBOL_CYCLES) + 1;
  localparam logic [TW-1:0] SYM_LAST  = TW'(SYMBOL_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(SYMBOL_CYCLES / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_bit;
  rx_state_e     state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    idx_q;
  logic [7:0]    shift_q;
  logic          done_q;

  assign rx_bit = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], serial_in_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!rx_bit) begin
            state_q <= RX_START;
            timer_q <= HALF_LAST;
          end
        end
        RX_START: begin
          if (timer_q == '0) begin
            if (rx_bit) begin
              state_q <= RX_IDLE;
            end else begin
              state_q <= RX_DATA;
              timer_q <= SYM_LAST;
              idx_q   <= '0;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        RX_DATA: begin
          if (timer_q == '0) begin
            shift_q <= {rx_bit, shift_q[7:1]};
            timer_q <= SYM_LAST;
            if (idx_q == 4'd7) state_q <= RX_STOP;
            else               idx_q   <= idx_q + 4'd1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        RX_STOP: begin
          if (timer_q == '0) begin
            state_q <= RX_IDLE;
            done_q  <= rx_bit;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o = shift_q;
  assign done_o = done_q;

endmodule

// File: rtl/mmio_uart_responder.sv
// MMIO responder for the IO region: UART TX/RX registers with 1-cycle load latency.
// Optional free-running cycle counter at offset 4 when MMIO_CYCLE_COUNTER_EN is defined.
module mmio_uart_responder
  import mmio_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                   clk,
  input  logic                   rst,
  mmio_uart_responder_if.slave   bus,
  input  logic                   serial_in_i,
  output logic                   serial_out_o
);

  localparam int SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(SYMBOL_CYCLES) + 1;
  localparam logic [TW-1:0] SYM_LAST = TW'(SYMBOL_CYCLES - 1);

  logic [3:0]  off;
  logic        wr;
  logic        tx_wr;
  logic        rd_rxdata;
  logic        unused_bits;

  assign off         = bus.addr[5:2];
  assign wr          = |bus.store_mask;
  assign tx_wr       = wr && (off == OFF_TXDATA);
  assign rd_rxdata   = bus.rd_en && (off == OFF_RXDATA);
  assign unused_bits = ^{bus.addr[31:6], bus.addr[1:0], bus.wd[31:8]};

  // TX: the start bit is driven at load time, the shifter feeds the remaining nine bits.
  tx_state_e     tx_state_q;
  logic [8:0]    tx_shift_q;
  logic [3:0]    tx_bit_q;
  logic [TW-1:0] tx_timer_q;
  logic          serial_out_q;
  logic          tx_ready;

  assign tx_ready = (tx_state_q == TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q   <= TX_IDLE;
      tx_shift_q   <= '1;
      tx_bit_q     <= '0;
      tx_timer_q   <= '0;
      serial_out_q <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_shift_q   <= {1'b1, bus.wd[7:0]};
            serial_out_q <= 1'b0;
            tx_bit_q     <= '0;
            tx_timer_q   <= SYM_LAST;
            tx_state_q   <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_timer_q == '0) begin
            if (tx_bit_q == 4'd9) begin
              tx_state_q <= TX_IDLE;
            end else begin
              serial_out_q <= tx_shift_q[0];
              tx_shift_q   <= {1'b1, tx_shift_q[8:1]};
              tx_bit_q     <= tx_bit_q + 4'd1;
              tx_timer_q   <= SYM_LAST;
            end
          end else begin
            tx_timer_q <= tx_timer_q - TW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign serial_out_o = serial_out_q;

  logic [7:0] rx_new_byte;
  logic       rx_done;

  uart_rx_fsm #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .serial_in_i(serial_in_i),
    .byte_o     (rx_new_byte),
    .done_o     (rx_done)
  );

  logic [31:0] cycles_rd;

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk) begin
    if (rst)                            cycles_q <= '0;
    else if (wr && (off == OFF_CYCLES)) cycles_q <= '0;
    else                                cycles_q <= cycles_q + 32'd1;
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic [31:0] rd_data_q, rd_mux;

  // A byte landing on the same edge as an RXDATA read counts as consumed-then-refilled.
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (rx_done) begin
      rx_byte_d  = rx_new_byte;
      rx_valid_d = 1'b1;
      overrun_d  = rd_rxdata ? 1'b0 : (overrun_q | rx_valid_q);
    end else if (rd_rxdata) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_TXCTRL: rd_mux = {31'b0, tx_ready};
      OFF_RXCTRL: rd_mux = {30'b0, overrun_q, rx_valid_q};
      OFF_RXDATA: rd_mux = {24'b0, rx_byte_q};
      OFF_CYCLES: rd_mux = cycles_rd;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (bus.rd_en) rd_data_q <= rd_mux;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Scoreboard bench for mmio_uart_responder (SYMBOL_CYCLES=10).
module tb_mmio_uart_responder;
  import mmio_pkg::*;

  logic clk;
  logic rst;
  logic serial_in;
  logic serial_out;

  mmio_uart_responder_if bus();

  mmio_uart_responder #(
    .CLOCK_FREQ(100),
    .BAUD_RATE (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .serial_in_i (serial_in),
    .serial_out_o(serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        rd_pend = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] last_exp = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: rd_data is due on the cycle after rd_en was sampled.
  always @(posedge clk) rd_pend <= bus.rd_en && !rst;

  always @(negedge clk) begin
    if (rst) begin
      last_exp = '0;
    end else if (rd_pend) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        check(n, bus.rd_data, e);
        last_exp = e;
      end
    end else if (hold_pend) begin
      check("rd_hold", bus.rd_data, last_exp);
    end
    hold_pend = rd_pend && !rst;
  end

  task automatic set_idle();
    bus.addr       = '0;
    bus.store_mask = '0;
    bus.wd         = '0;
    bus.rd_en      = 1'b0;
  endtask

  task automatic rd_issue(input logic [3:0] off, input logic [31:0] exp, input string nm);
    bus.addr       = {26'b0, off, 2'b00};
    bus.store_mask = '0;
    bus.rd_en      = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
  endtask

  task automatic wr_issue(input logic [3:0] off, input logic [31:0] data);
    bus.addr       = {26'b0, off, 2'b00};
    bus.store_mask = 4'hF;
    bus.wd         = data;
    bus.rd_en      = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string nm);
    @(negedge clk);
    rd_issue(off, exp, nm);
    @(negedge clk);
    set_idle();
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data);
    @(negedge clk);
    wr_issue(off, data);
    @(negedge clk);
    set_idle();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      serial_in = f[k];
      repeat (9) @(negedge clk);
    end
    @(negedge clk);
    serial_in = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [9:0] txf;
    logic [9:0] rxf;
    rst       = 1'b1;
    serial_in = 1'b1;
    set_idle();
    repeat (3) @(negedge clk);
    check("rst_serial_out", {31'b0, serial_out}, 32'h1);
    check("rst_rd_data", bus.rd_data, 32'h0);
    rst = 1'b0;

    rd(OFF_TXCTRL, 32'h1, "rst_txctrl");
    rd(OFF_RXCTRL, 32'h0, "rst_rxctrl");
    rd(OFF_RXDATA, 32'h0, "rst_rxdata");
    rd(4'hF,       32'h0, "unmapped_rd");
    wr(OFF_TXCTRL, 32'h0);
    rd(OFF_TXCTRL, 32'h1, "ro_write_ignored");

    // TX frame 0xA5 with a dropped write while busy.
    txf = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    wr_issue(OFF_TXDATA, 32'h0000_00A5);
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      set_idle();
      if (i == 20)  wr_issue(OFF_TXDATA, 32'h0000_0000);
      if (i == 30)  rd_issue(OFF_TXCTRL, 32'h0, "tx_busy_ready");
      if (i == 110) rd_issue(OFF_TXCTRL, 32'h1, "tx_done_ready");
      if ((i % 10) == 6 && i <= 96)
        check($sformatf("tx_bit%0d", (i - 6) / 10), {31'b0, serial_out}, {31'b0, txf[(i - 6) / 10]});
      if (i == 105 || i == 115) check("tx_idle_high", {31'b0, serial_out}, 32'h1);
    end
    @(negedge clk);
    set_idle();

    // Single RX frame.
    send_frame(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    rd(OFF_RXCTRL, 32'h1,  "rx_valid");
    rd(OFF_RXDATA, 32'h3C, "rx_data_3c");
    rd(OFF_RXCTRL, 32'h0,  "rx_cleared");

    // Overrun.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    rd(OFF_RXCTRL, 32'h3,  "rx_overrun");
    rd(OFF_RXDATA, 32'h22, "rx_data_22");
    rd(OFF_RXCTRL, 32'h0,  "rx_ovr_cleared");

    // Glitch and framing error, then a good frame.
    @(negedge clk);
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    rd(OFF_RXCTRL, 32'h0, "rx_glitch_frame_err");
    send_frame(8'h7E, 1'b1);
    repeat (5) @(negedge clk);
    rd(OFF_RXCTRL, 32'h1, "rx_valid_7e");

    // Byte 0x99 completes on the same edge that RXDATA is read.
    rxf = {1'b1, 8'h99, 1'b0};
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      serial_in = rxf[c / 10];
      set_idle();
      if (c == 98) rd_issue(OFF_RXDATA, 32'h7E, "rx_simul_old");
    end
    @(negedge clk);
    serial_in = 1'b1;
    set_idle();
    repeat (5) @(negedge clk);
    rd(OFF_RXCTRL, 32'h1,  "rx_simul_ctrl");
    rd(OFF_RXDATA, 32'h99, "rx_simul_new");
    rd(OFF_RXCTRL, 32'h0,  "rx_simul_cleared");

    // Cycle counter: cleared by the write, read after five further cycles.
    wr(OFF_CYCLES, 32'h0);
    repeat (4) @(negedge clk);
`ifdef MMIO_CYCLE_COUNTER_EN
    rd(OFF_CYCLES, 32'd5, "cycles");
`else
    rd(OFF_CYCLES, 32'd0, "cycles_absent");
`endif

    // Reset in the middle of a TX frame.
    wr(OFF_TXDATA, 32'h0000_00A5);
    repeat (2) @(negedge clk);
    check("tx_start_low", {31'b0, serial_out}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frame", {31'b0, serial_out}, 32'h1);
    rst = 1'b0;
    rd(OFF_TXCTRL, 32'h1, "rst_mid_ready");

    repeat (5) @(negedge clk);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_responder.md
Name: mmio_uart_responder

Overview:
Memory-mapped IO responder for the MIPS150 pipeline. It answers the CPU's IO-region loads and stores (TopAddr 4'h8) and owns a UART transmitter/receiver pair.
- Stores and load requests arrive in the X stage.
- Load data returns one cycle later, in the M stage, matching DMEM's synchronous-read timing.
- It replaces the constant dummy IO read data in the datapath.

Parameters:
CLOCK_FREQ, 50_000_000, core clock in Hz
BAUD_RATE, 115_200, UART bit rate
SYMBOL_CYCLES, CLOCK_FREQ/BAUD_RATE, derived clock cycles per UART bit (localparam, not overridable)

Ports:
clk  in  1  core clock
rst  in  1  reset
addr  in  32  X-stage ALU result; only addr[5:2] decoded
store_mask  in  4  X-stage IO byte-write mask; nonzero means store
wd  in  32  X-stage store data; byte payload in wd[7:0]
rd_en  in  1  X-stage load targeting IO region
rd_data  out  32  M-stage load data, valid the cycle after rd_en
serial_in  in  1  UART RX line, asynchronous
serial_out  out  1  UART TX line

Behaviour:
Interface:
- Reset rst, synchronous, active-high; clock clk.

Reset values:
- serial_out=1, rd_data=0, tx_ready=1, rx_valid=0, overrun=0, cycle counter=0.
- Reset mid-frame abandons the frame; serial_out is high on the first cycle after reset.

Register map (word offset addr[5:2]):
- 0 TXCTRL, read-only: bit0 = tx_ready.
- 1 RXCTRL, read-only: bit0 = rx_valid, bit1 = overrun.
- 2 TXDATA, write-only: wd[7:0].
- 3 RXDATA, read-only: {24'b0, byte}.
- 4 CYCLES: optional; see below.
- Unmapped reads return 0. Unmapped or read-only writes are ignored.

Read path:
- rd_data is registered at the edge where rd_en is sampled, so it is 1-cycle latency. It holds its value when rd_en=0.
- A read of RXDATA returns the current byte, then clears rx_valid and overrun at that same edge.

TX FSM, states IDLE -> SEND:
- A TXDATA write with tx_ready=1 loads the 10-bit frame {stop=1, data, start=0}. tx_ready falls on the next cycle.
- Bits go out LSB-first, each held SYMBOL_CYCLES cycles.
- tx_ready rises after the stop bit's final cycle.
- A TXDATA write while tx_ready=0 is dropped silently.

RX FSM, states IDLE -> START -> DATA -> STOP:
- serial_in passes through a 2-flop synchronizer.
- IDLE: a synchronized low moves to START. Sample at SYMBOL_CYCLES/2; if the line is high there, it was a false start and the FSM returns to IDLE.
- DATA: 8 bits sampled at mid-bit, LSB first.
- STOP: if the stop bit is 0, it is a framing error; the byte is discarded and the FSM returns to IDLE.
- Otherwise the byte goes to RXDATA and rx_valid is set.
- If rx_valid was already 1, the new byte overwrites and overrun is set.
- Simultaneous byte completion and RXDATA read: the read returns the old byte; the new byte is stored, rx_valid stays 1, overrun stays clear.

Counters and arithmetic:
- Bit-timer counters are sized $clog2(SYMBOL_CYCLES)+1.
- The bit index is 4 bits.

Optional Feature:
MMIO_CYCLE_COUNTER_EN
- Defined:
  - Offset 4 is a free-running 32-bit cycle counter that wraps 32'hFFFF_FFFF -> 0.
  - Any write to offset 4 zeroes it on that edge.
  - A simultaneous read returns the pre-clear value.
- Undefined: offset 4 reads 0, writes are ignored, and no counter logic is present.

Decomposition:
- Package mmio_pkg holds:
  - IO region nibble 4'h8;
  - word-offset constants OFF_TXCTRL..OFF_CYCLES;
  - the TX state enum and the RX state enum.
- One sub-module: uart_rx_fsm (synchronizer, bit timer, deserializer; outputs a byte plus a 1-cycle done pulse). TX, register file and read mux stay in the top module.

Test Plan (bench CLOCK_FREQ=100, BAUD_RATE=10, so SYMBOL_CYCLES=10):
- Reset then read TXCTRL -> rd_data=32'h1 one cycle after rd_en; serial_out=1.
- Write 8'hA5 to TXDATA -> serial_out=0 for 10 cycles, then 1,0,1,0,0,1,0,1 (10 cycles each), then 1. tx_ready=0 during the frame and 1 after 100 cycles. A second write at cycle 20 is dropped.
- Drive frame 8'h3C on serial_in -> rx_valid=1. RXDATA read returns 32'h3C, then RXCTRL reads 32'h0.
- Two frames 8'h11 then 8'h22 with no read -> RXCTRL=32'h3, RXDATA=32'h22; after the read, RXCTRL=0.
- 3-cycle low glitch on serial_in, then a frame with stop bit 0 -> rx_valid stays 0; the next valid frame 8'h7E is received correctly.
- With MMIO_CYCLE_COUNTER_EN: write offset 4, read it 5 cycles later -> 32'd5. Without the macro: reads 0.
